// File: rtl/demod_pkg.sv
// Shared types and sizes for the demodulation segment serializer.
// State encoding and segment indexing used by the FSM and buffer.
package demod_pkg;
  localparam int NUM_SEG   = 10;
  localparam int SEG_IDX_W = 4;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SEND
  } state_t;
endpackage

// File: rtl/demod_frame_buffer.sv
// Ten-word capture register with indexed read and XOR reduction.
// The XOR is latched alongside the words so it tracks the captured frame.
module demod_frame_buffer
  import demod_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [NUM_SEG-1:0][WIDTH-1:0] seg,
  input  logic [SEG_IDX_W-1:0]          idx,
  output logic [WIDTH-1:0]              rd_data,
  output logic [WIDTH-1:0]              frame_xor
);

  logic [NUM_SEG-1:0][WIDTH-1:0] mem;
  logic [WIDTH-1:0]              seg_xor;

  always_comb begin
    seg_xor = '0;
    for (int i = 0; i < NUM_SEG; i++)
      seg_xor = seg_xor ^ seg[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem       <= '0;
      frame_xor <= '0;
    end else if (load) begin
      mem       <= seg;
      frame_xor <= seg_xor;
    end
  end

  always_comb begin
    rd_data = '0;
    if (idx < SEG_IDX_W'(NUM_SEG))
      rd_data = mem[idx];
  end

endmodule

// File: rtl/demod_segment_serializer.sv
// Requests a frame upstream, captures ten segments, streams them out
// on a valid/ready port with index, last tag, frame XOR and frame count.
module demod_segment_serializer
  import demod_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_SEG = 10,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 up_start,
  input  logic                 up_valid,
  input  logic [WIDTH-1:0]     segment_0,
  input  logic [WIDTH-1:0]     segment_1,
  input  logic [WIDTH-1:0]     segment_2,
  input  logic [WIDTH-1:0]     segment_3,
  input  logic [WIDTH-1:0]     segment_4,
  input  logic [WIDTH-1:0]     segment_5,
  input  logic [WIDTH-1:0]     segment_6,
  input  logic [WIDTH-1:0]     segment_7,
  input  logic [WIDTH-1:0]     segment_8,
  input  logic [WIDTH-1:0]     segment_9,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEG_IDX_W-1:0] out_index,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [WIDTH-1:0]     frame_xor,
  output logic [CNT_W-1:0]     frame_count,
  output logic                 busy
);

  localparam logic [SEG_IDX_W-1:0] LAST = SEG_IDX_W'(NUM_SEG - 1);

  state_t                   state, state_nxt;
  logic [SEG_IDX_W-1:0]     idx_nxt;
  logic [CNT_W-1:0]         cnt_nxt;
  logic                     load;
  logic [9:0][WIDTH-1:0]    seg;

  assign seg = {segment_9, segment_8, segment_7, segment_6, segment_5,
                segment_4, segment_3, segment_2, segment_1, segment_0};

  demod_frame_buffer #(.WIDTH(WIDTH)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .seg       (seg),
    .idx       (out_index),
    .rd_data   (out_data),
    .frame_xor (frame_xor)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      out_index   <= '0;
      frame_count <= '0;
    end else begin
      state       <= state_nxt;
      out_index   <= idx_nxt;
      frame_count <= cnt_nxt;
    end
  end

  // A started request always runs to a full frame; enable only
  // decides whether another request follows.
  always_comb begin
    state_nxt = state;
    idx_nxt   = out_index;
    cnt_nxt   = frame_count;
    load      = 1'b0;
    unique case (state)
      IDLE: if (enable) state_nxt = REQ;
      REQ: begin
        if (up_valid) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (out_index == LAST) begin
            idx_nxt   = '0;
            cnt_nxt   = frame_count + CNT_W'(1);
            state_nxt = enable ? REQ : IDLE;
          end else begin
            idx_nxt = out_index + SEG_IDX_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign up_start  = (state == REQ);
  assign out_valid = (state == SEND);
  assign out_last  = out_valid && (out_index == LAST);
  assign busy      = (state != IDLE);

endmodule

// File: doc/demod_segment_serializer.md
Name: demod_segment_serializer

Overview:
- Sits directly downstream of the 6th-stage demodulation segment block (ten 32-bit segment outputs plus start/valid/busy control).
- Drives that stage's start, captures all ten segments when its valid rises, then streams them out one word per handshake on a valid/ready interface.
- Tags the last word with a frame XOR checksum and keeps a running frame count for the next pipe stage.

Parameters:
- WIDTH, 32, width of each segment word and of the output word
- NUM_SEG, 10, segments per frame; fixed at 10, matching the upstream port count
- CNT_W, 16, width of frame_count

Ports:
- clk  input  1  system clock, all logic on posedge
- reset  input  1  synchronous, active-high reset
- enable  input  1  continuous-run request; frames are fetched while high
- up_start  output  1  start to upstream stage; held high until up_valid
- up_valid  input  1  upstream valid: segments are stable while high
- segment_0 .. segment_9  input  WIDTH each  upstream segment words
- out_data  output  WIDTH  current serialized word
- out_index  output  4  index 0..9 of out_data within frame
- out_valid  output  1  out_data/out_index/out_last valid
- out_ready  input  1  downstream accepts word when out_valid && out_ready
- out_last  output  1  high with index 9
- frame_xor  output  WIDTH  XOR of all ten captured words, valid with out_last
- frame_count  output  CNT_W  number of completed frames, wraps modulo 2^CNT_W
- busy  output  1  high in any state other than IDLE

Behaviour:
- One clock domain; reset is synchronous and active-high (clk, reset), all registered outputs cleared.
- Reset values: up_start=0, out_valid=0, out_last=0, out_index=0, out_data=0, frame_xor=0, frame_count=0, busy=0, state=IDLE, capture buffer=0.
- FSM states and transitions:
  - IDLE -> REQ when enable=1.
  - REQ: up_start=1; on up_valid=1 capture all ten segments and the XOR into the buffer, then -> SEND.
    - The upstream counter saturates, so up_valid arrives 3 cycles after up_start rises.
  - SEND: up_start=0, out_valid=1, out_data=buf[out_index].
    - On handshake with out_index<9: out_index+1.
    - On handshake with out_index=9: frame_count+1, out_index=0, then -> REQ if enable=1, else -> IDLE.
  - Without out_ready, out_data, out_index and out_valid hold stable; no word is dropped or repeated.
- Latency:
  - up_start high to first out_valid is 4 cycles: 3 for the upstream stage plus 1 for capture.
  - With out_ready tied high, a frame occupies 10 SEND cycles.
  - Steady-state period with enable and out_ready held high is 14 cycles per frame.
- up_start is low for at least the 10 SEND cycles, which guarantees the upstream counter clears before the next request.
- up_valid is ignored outside REQ.
- enable deasserted during REQ: keep waiting for up_valid and complete that frame; return to IDLE afterwards. A requested frame is never abandoned.
- enable deasserted during SEND: finish the frame, then IDLE.
- out_last = out_valid && out_index==9. frame_xor is updated at capture and holds until the next capture.
- frame_count wraps from 2^CNT_W-1 to 0 with no flag.
- reset mid-frame: abort immediately, buffer cleared, up_start=0 in the next cycle; the partial frame is not counted.
- busy = (state != IDLE).

Decomposition:
- Shared package demod_pkg: state enum (IDLE, REQ, SEND), NUM_SEG, SEG_IDX_W=4, default WIDTH.
- One natural sub-module, demod_frame_buffer: ten-word capture register array with a load strobe, a read mux by index, and XOR reduction.
- The FSM and handshake live in the top.

Test Plan:
- Reset then enable=1 with the upstream model (counter to 3) and segments k*0x11111111 for k=0..9, out_ready=1 -> up_start at cycle 1, first out_valid 4 cycles later, words 0x00000000..0x99999999 in order, out_last on index 9, frame_xor=0x11111111, frame_count=1.
- Same stimulus with out_ready toggling 1,0,0,1 -> each word held stable while out_ready=0, exactly 10 handshakes, no repeats.
- enable held high, out_ready=1, 3 frames -> 14-cycle period, up_start low at least 10 cycles between requests, frame_count=3.
- Drop enable during REQ before up_valid -> frame still captured and sent, then IDLE, busy=0, up_start=0.
- Assert reset at out_index=5 -> next cycle out_valid=0, up_start=0, frame_count unchanged (0), busy=0.
- Preload frame_count near wrap (CNT_W=4 build) and run 2 frames from 15 -> count reads 0 then 1.
